// File: rtl/ax_level_controller.sv
// ax_level_controller: runtime holder of the core approximation level.
// A CSR write stalls fetch, waits for the back-end to drain and only then
// commits the new level, so every approximation-aware unit sees exactly one
// level per instruction. A drain that never completes is aborted after
// DRAIN_TIMEOUT cycles, leaving the level untouched.
module ax_level_controller #(
    parameter int AX_LEVEL_WIDTH   = 4,
    parameter int DEFAULT_AX_LEVEL = 10,
    parameter int MAX_AX_LEVEL     = 15,
    parameter int DRAIN_TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wrValid,
    input  logic [AX_LEVEL_WIDTH-1:0] wrData,
    output logic                      wrReady,
    input  logic                      activeListEmpty,
    input  logic                      memQueuesEmpty,
    output logic                      fetchStall,
    output logic [AX_LEVEL_WIDTH-1:0] axLevel,
    output logic                      levelChanged,
    output logic                      wrDone,
    output logic                      wrAbort
);

    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [AX_LEVEL_WIDTH-1:0] DEF_L     = AX_LEVEL_WIDTH'(DEFAULT_AX_LEVEL);
    localparam logic [AX_LEVEL_WIDTH-1:0] MAX_L     = AX_LEVEL_WIDTH'(MAX_AX_LEVEL);
    localparam logic [CNT_W-1:0]          TIMEOUT_C = CNT_W'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t                      state;
    logic [AX_LEVEL_WIDTH-1:0]   pending;
    logic [CNT_W-1:0]            drain_cnt;
    logic [AX_LEVEL_WIDTH-1:0]   eff_level;
    logic                        drained;

    // Requests above the architectural maximum saturate rather than wrap.
    assign eff_level = (wrData > MAX_L) ? MAX_L : wrData;
    assign drained   = activeListEmpty && memQueuesEmpty;

    // Accepting only in IDLE keeps wrReady a pure function of state.
    assign wrReady = (state == IDLE);

    // Level-change FSM; all outputs except wrReady are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            axLevel      <= DEF_L;
            pending      <= DEF_L;
            drain_cnt    <= '0;
            fetchStall   <= 1'b0;
            levelChanged <= 1'b0;
            wrDone       <= 1'b0;
            wrAbort      <= 1'b0;
        end else begin
            levelChanged <= 1'b0;
            wrDone       <= 1'b0;
            wrAbort      <= 1'b0;
            case (state)
                IDLE: begin
                    if (wrValid) begin
                        if (eff_level == axLevel) begin
                            // Same level: complete without disturbing fetch.
                            wrDone <= 1'b1;
                        end else begin
                            pending    <= eff_level;
                            drain_cnt  <= '0;
                            fetchStall <= 1'b1;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // A drain seen in the timeout cycle still wins.
                    if (drained) begin
                        state <= APPLY;
                    end else if (drain_cnt == TIMEOUT_C) begin
                        fetchStall <= 1'b0;
                        wrAbort    <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                APPLY: begin
                    axLevel      <= pending;
                    levelChanged <= 1'b1;
                    wrDone       <= 1'b1;
                    fetchStall   <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    fetchStall <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ax_level_controller.sv
// Directed bench for ax_level_controller: a per-cycle vector table for the
// basic write / clamp / no-op flows, then hand-written multi-cycle sequences
// for delayed drain, timeout, back-pressure and asynchronous reset.
module tb_ax_level_controller;

    logic       clk;
    logic       rst;

    // Main instance: 5-bit data so out-of-range writes can be expressed.
    logic       wr_valid;
    logic [4:0] wr_data;
    logic       wr_ready;
    logic       al_empty;
    logic       mq_empty;
    logic       fetch_stall;
    logic [4:0] ax_level;
    logic       level_changed;
    logic       wr_done;
    logic       wr_abort;

    // Short-timeout instance for the abort corner cases.
    logic       t_wr_valid;
    logic [3:0] t_wr_data;
    logic       t_wr_ready;
    logic       t_al_empty;
    logic       t_mq_empty;
    logic       t_fetch_stall;
    logic [3:0] t_ax_level;
    logic       t_level_changed;
    logic       t_wr_done;
    logic       t_wr_abort;

    int checks = 0;
    int errors = 0;

    ax_level_controller #(
        .AX_LEVEL_WIDTH(5), .DEFAULT_AX_LEVEL(10), .MAX_AX_LEVEL(15), .DRAIN_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .wrValid(wr_valid), .wrData(wr_data), .wrReady(wr_ready),
        .activeListEmpty(al_empty), .memQueuesEmpty(mq_empty),
        .fetchStall(fetch_stall), .axLevel(ax_level),
        .levelChanged(level_changed), .wrDone(wr_done), .wrAbort(wr_abort)
    );

    ax_level_controller #(
        .AX_LEVEL_WIDTH(4), .DEFAULT_AX_LEVEL(10), .MAX_AX_LEVEL(15), .DRAIN_TIMEOUT(4)
    ) dut_to (
        .clk(clk), .rst(rst),
        .wrValid(t_wr_valid), .wrData(t_wr_data), .wrReady(t_wr_ready),
        .activeListEmpty(t_al_empty), .memQueuesEmpty(t_mq_empty),
        .fetchStall(t_fetch_stall), .axLevel(t_ax_level),
        .levelChanged(t_level_changed), .wrDone(t_wr_done), .wrAbort(t_wr_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] d;
        logic       ae;
        logic       me;
        logic [4:0] lvl;
        logic       st;
        logic       ch;
        logic       dn;
        logic       ab;
        logic       rdy;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(int v, int d, int ae, int me, int lvl,
                                int st, int ch, int dn, int ab, int rdy);
        vec_t r;
        r.v   = (v != 0);
        r.d   = 5'(d);
        r.ae  = (ae != 0);
        r.me  = (me != 0);
        r.lvl = 5'(lvl);
        r.st  = (st != 0);
        r.ch  = (ch != 0);
        r.dn  = (dn != 0);
        r.ab  = (ab != 0);
        r.rdy = (rdy != 0);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n;
    int pulses;

    initial begin
        // Row i: inputs held through cycle i, outputs expected in cycle i+1.
        //           v  d  ae me lvl st ch dn ab rdy
        // write 3 with immediate drain
        vecs[0]  = mk(1,  3, 1, 1, 10, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0,  0, 1, 1, 10, 1, 0, 0, 0, 0);
        vecs[2]  = mk(0,  0, 1, 1,  3, 0, 1, 1, 0, 1);
        vecs[3]  = mk(0,  0, 1, 1,  3, 0, 0, 0, 0, 1);
        // write 15
        vecs[4]  = mk(1, 15, 1, 1,  3, 1, 0, 0, 0, 0);
        vecs[5]  = mk(0,  0, 1, 1,  3, 1, 0, 0, 0, 0);
        vecs[6]  = mk(0,  0, 1, 1, 15, 0, 1, 1, 0, 1);
        // no-op 15, then back-to-back 31 which clamps to 15 (also a no-op)
        vecs[7]  = mk(1, 15, 1, 1, 15, 0, 0, 1, 0, 1);
        vecs[8]  = mk(1, 31, 1, 1, 15, 0, 0, 1, 0, 1);
        vecs[9]  = mk(0,  0, 1, 1, 15, 0, 0, 0, 0, 1);
        // write 12
        vecs[10] = mk(1, 12, 1, 1, 15, 1, 0, 0, 0, 0);
        vecs[11] = mk(0,  0, 1, 1, 15, 1, 0, 0, 0, 0);
        vecs[12] = mk(0,  0, 1, 1, 12, 0, 1, 1, 0, 1);
        // write 20 clamps to 15
        vecs[13] = mk(1, 20, 1, 1, 12, 1, 0, 0, 0, 0);
        vecs[14] = mk(0,  0, 1, 1, 12, 1, 0, 0, 0, 0);
        vecs[15] = mk(0,  0, 1, 1, 15, 0, 1, 1, 0, 1);
        vecs[16] = mk(0,  0, 1, 1, 15, 0, 0, 0, 0, 1);

        rst = 1'b1;
        wr_valid = 1'b0; wr_data = '0; al_empty = 1'b1; mq_empty = 1'b1;
        t_wr_valid = 1'b0; t_wr_data = '0; t_al_empty = 1'b0; t_mq_empty = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #2; // settle away from the edge

        // Reset state
        chk("rst_level", int'(ax_level), 10);
        chk("rst_stall", int'(fetch_stall), 0);
        chk("rst_ready", int'(wr_ready), 1);
        chk("rst_pulses", int'({level_changed, wr_done, wr_abort}), 0);
        chk("rst_to_level", int'(t_ax_level), 10);

        // Table-driven flows
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) begin
            wr_valid = vecs[i].v;
            wr_data  = vecs[i].d;
            al_empty = vecs[i].ae;
            mq_empty = vecs[i].me;
            step();
            chk($sformatf("v%0d_level", i),   int'(ax_level),      int'(vecs[i].lvl));
            chk($sformatf("v%0d_stall", i),   int'(fetch_stall),   int'(vecs[i].st));
            chk($sformatf("v%0d_changed", i), int'(level_changed), int'(vecs[i].ch));
            chk($sformatf("v%0d_done", i),    int'(wr_done),       int'(vecs[i].dn));
            chk($sformatf("v%0d_abort", i),   int'(wr_abort),      int'(vecs[i].ab));
            chk($sformatf("v%0d_ready", i),   int'(wr_ready),      int'(vecs[i].rdy));
        end

        // Delayed drain: write 5, active list busy for 7 DRAIN cycles.
        wr_valid = 1'b1; wr_data = 5'd5; al_empty = 1'b1; mq_empty = 1'b1;
        step();
        wr_valid = 1'b0; al_empty = 1'b0;
        n = 0;
        while (fetch_stall && n < 30) begin
            if (n < 8) chk("dd_level_hold", int'(ax_level), 15);
            if (n == 7) al_empty = 1'b1;
            n++;
            step();
        end
        chk("dd_stall_cycles", n, 9);
        chk("dd_level", int'(ax_level), 5);
        chk("dd_changed", int'(level_changed), 1);
        chk("dd_done", int'(wr_done), 1);
        step();
        chk("dd_changed_once", int'(level_changed), 0);

        // Timeout on the short-timeout instance: never drains.
        t_wr_valid = 1'b1; t_wr_data = 4'd3;
        step();
        t_wr_valid = 1'b0;
        n = 1;
        while (!t_wr_abort && n < 20) begin
            chk("to_stall_during", int'(t_fetch_stall), 1);
            step();
            n++;
        end
        chk("to_abort_cycle", n, 6);
        chk("to_level", int'(t_ax_level), 10);
        chk("to_stall_low", int'(t_fetch_stall), 0);
        chk("to_ready", int'(t_wr_ready), 1);
        chk("to_no_done", int'(t_wr_done), 0);
        step();
        chk("to_abort_once", int'(t_wr_abort), 0);

        // Timeout with emptiness arriving exactly in the timeout cycle.
        t_wr_valid = 1'b1; t_wr_data = 4'd3;
        step();
        t_wr_valid = 1'b0;
        repeat (4) step();            // now in T+5, counter at the limit
        t_al_empty = 1'b1; t_mq_empty = 1'b1;
        step();                       // T+6: APPLY
        chk("tw_abort", int'(t_wr_abort), 0);
        chk("tw_stall", int'(t_fetch_stall), 1);
        step();                       // T+7
        chk("tw_level", int'(t_ax_level), 3);
        chk("tw_changed", int'(t_level_changed), 1);
        chk("tw_done", int'(t_wr_done), 1);
        chk("tw_abort2", int'(t_wr_abort), 0);

        // Back-pressure: write 2, then hold write 7 until accepted.
        pulses = 0;
        wr_valid = 1'b1; wr_data = 5'd2;
        step();                       // T+1 DRAIN
        wr_data = 5'd7;
        chk("bp_ready_t1", int'(wr_ready), 0);
        step();                       // T+2 APPLY, 7 not taken
        chk("bp_ready_t2", int'(wr_ready), 0);
        chk("bp_level_t2", int'(ax_level), 5);
        step();                       // T+3 IDLE, 7 taken at this edge
        pulses += int'(level_changed);
        chk("bp_level_t3", int'(ax_level), 2);
        chk("bp_ready_t3", int'(wr_ready), 1);
        step();                       // T+4 DRAIN for 7
        wr_valid = 1'b0;
        pulses += int'(level_changed);
        chk("bp_stall_t4", int'(fetch_stall), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            pulses += int'(level_changed);
        end
        chk("bp_level_final", int'(ax_level), 7);
        chk("bp_pulses", pulses, 2);

        // Asynchronous reset mid-DRAIN.
        al_empty = 1'b0;
        wr_valid = 1'b1; wr_data = 5'd9;
        step();
        wr_valid = 1'b0;
        step();
        chk("ar_in_drain", int'(fetch_stall), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_level", int'(ax_level), 10);
        chk("ar_stall", int'(fetch_stall), 0);
        chk("ar_ready", int'(wr_ready), 1);
        #3 rst = 1'b0;
        al_empty = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            pulses += int'(level_changed) + int'(wr_done) + int'(wr_abort) + int'(fetch_stall);
        end
        chk("ar_quiet", pulses, 0);
        chk("ar_level_after", int'(ax_level), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so a stuck sequence cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ax_level_controller.md
# ax_level_controller

Runtime holder of the core's approximation level. Reset loads the compile-time default level. Software writes a new level through a CSR write handshake. The block stalls fetch, waits for the back-end (active list and load/store queues) to drain, and only then commits the new level. Every approximation-aware unit (AX-BTB, approximate execution paths) therefore sees one consistent level per instruction. It sits beside the CSR unit and drives fetch-stall into the front-end.

## Interface
- AX_LEVEL_WIDTH, 4: bit width of the level value.
- DEFAULT_AX_LEVEL, 10: level loaded on reset; must be ≤ MAX_AX_LEVEL.
- MAX_AX_LEVEL, 15: writes above this are clamped to it.
- DRAIN_TIMEOUT, 255: maximum cycles spent waiting for the drain before the request is aborted; counter width is $clog2(DRAIN_TIMEOUT+1).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- wrValid  in  1  CSR write request.
- wrData  in  AX_LEVEL_WIDTH  requested level.
- wrReady  out  1  request accepted this cycle when wrValid && wrReady.
- activeListEmpty  in  1  ROB holds no instructions.
- memQueuesEmpty  in  1  load queue and store queue both empty.
- fetchStall  out  1  front-end must not fetch new instructions.
- axLevel  out  AX_LEVEL_WIDTH  committed approximation level, registered.
- levelChanged  out  1  one-cycle pulse in the cycle axLevel takes a new value.
- wrDone  out  1  one-cycle pulse when a request completes (applied or no-op).
- wrAbort  out  1  one-cycle pulse when a request times out; axLevel unchanged.

## Operation
- States: IDLE, DRAIN, APPLY. Reset value of each output:
  - state IDLE
  - axLevel = DEFAULT_AX_LEVEL
  - pending level = DEFAULT_AX_LEVEL
  - counter = 0
  - fetchStall = 0, levelChanged = 0, wrDone = 0, wrAbort = 0
  - wrReady = 1
- wrReady = (state == IDLE). It is combinational from state and does not depend on wrValid.
- Clamp: eff = (wrData > MAX_AX_LEVEL) ? MAX_AX_LEVEL : wrData. The compare is unsigned.
- IDLE, on accept:
  - If eff == axLevel: stay in IDLE and pulse wrDone next cycle. No stall and no levelChanged.
  - Otherwise: latch pending = eff, clear counter, go to DRAIN.
- DRAIN:
  - fetchStall = 1.
  - Each cycle, if activeListEmpty && memQueuesEmpty, go to APPLY.
  - Else if counter == DRAIN_TIMEOUT, go to IDLE and pulse wrAbort.
  - Else increment counter.
  - The drain check takes priority over the timeout when both hold in the same cycle.
- APPLY (exactly one cycle):
  - fetchStall = 1.
  - axLevel <= pending, registered at the end of APPLY.
  - levelChanged and wrDone pulse in the cycle after APPLY, coincident with the new axLevel.
  - Go to IDLE.
- wrValid while not in IDLE is ignored (wrReady = 0). The requester must hold the request until it is accepted.
- Asynchronous rst in any state returns to IDLE immediately and drops fetchStall. axLevel returns to DEFAULT_AX_LEVEL, and any pending request is discarded with no pulse.
- Pulses are registered outputs and are never asserted for more than one cycle.

## Timing
- Accept at cycle T with an immediate drain (both empty inputs high in T+1):
  - DRAIN at T+1, APPLY at T+2.
  - New axLevel, levelChanged and wrDone visible at T+3.
  - fetchStall high in T+1..T+2, low at T+3.
  - wrReady high again at T+3.
- Each drain cycle that fails the empty check adds one cycle.
- Abort: the counter reaches DRAIN_TIMEOUT after DRAIN_TIMEOUT failed cycles. wrAbort is high on the following cycle, together with the return to IDLE and fetchStall low.
- No-op write at T: wrDone at T+1, wrReady stays high throughout, back-to-back accepts allowed.
- No combinational path from any input to any output except wrReady, which depends on state only.

## Test plan
- Reset: assert rst mid-DRAIN → axLevel=10, fetchStall=0, wrReady=1 the same cycle; no pulses after release.
- Normal write: wrData=3 with both empties held high → fetchStall high for 2 cycles; at T+3 axLevel=3, levelChanged=1, wrDone=1 for one cycle.
- Clamp and no-op: with axLevel=15, write wrData=15 → wrDone at T+1, no stall, no levelChanged. Write to 12 (stalls 2 cycles, levelChanged) then wrData=20 → axLevel=15 after drain.
- Delayed drain: write 5, hold activeListEmpty low for 7 cycles, then high → APPLY 8 cycles after DRAIN entry; fetchStall high for 9 cycles total; then axLevel=5.
- Timeout: DRAIN_TIMEOUT=4, emptiness never asserted → wrAbort pulses 6 cycles after accept (T+6), axLevel unchanged, fetchStall low at T+6. Repeat with emptiness rising exactly in the timeout cycle → apply wins.
- Back-pressure: hold wrValid with data 7 during DRAIN of a prior write to 2 → second write accepted only at the cycle wrReady rises. Final axLevel=7, two levelChanged pulses.
